vga_vram_control_read_pixel: RTL

VGA_VRAM_CONTROL_READ_PIXEL -- requirements
Module: vga_vram_control_read_pixel

---
 rtl/vga_vram_control_read_pixel.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vga_vram_control_read_pixel.sv
// VRAM pixel prefetcher: streams frame pixels from memory into a first-word-fall-through FIFO for the display.
// Optional sticky underrun flag is built only when VGA_READ_PIXEL_UNDERRUN_EN is defined.
module vga_vram_control_read_pixel #(
  parameter int FRAME_PIXELS = 307200,
  parameter int FIFO_DEPTH   = 64,
  parameter int FIFO_DEPTH_N = 6
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC_IF,
  input  logic        iFRAME_START,
  input  logic        iDISP_REQ,
  output logic        oDISP_VALID,
  output logic [15:0] oDISP_DATA,
  output logic        oDISP_UNDERRUN,
  output logic        oMEM_REQ,
  output logic [18:0] oMEM_ADDR,
  input  logic        iMEM_BUSY,
  input  logic        iMEM_VALID,
  input  logic [15:0] iMEM_DATA
);
  // state | meaning
  // IDLE  | no reads issued; waits for iFRAME_START
  // FETCH | reads issued in address order while FIFO credit allows
  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic                    flush, accept, drop, push, pop;
  logic                    mem_req_q, mem_req_d;
  logic [18:0]             addr_q, addr_d;
  logic [6:0]              outstanding_q, outstanding_d;
  logic [6:0]              discard_q, discard_d;
  logic [FIFO_DEPTH_N:0]   fifo_count_q, fifo_count_d;
  logic [FIFO_DEPTH_N-1:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]              credit_sum;
  logic [15:0]             fifo_mem [FIFO_DEPTH];

  assign flush  = iRESET_SYNC_IF | iFRAME_START;
  assign accept = mem_req_q & ~iMEM_BUSY;
  // Returns belonging to a previous frame (or arriving with a flush) never reach the FIFO.
  assign drop   = iMEM_VALID & (flush | (discard_q != 7'd0));
  assign push   = iMEM_VALID & ~drop;
  assign pop    = iDISP_REQ & oDISP_VALID & ~flush;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (iRESET_SYNC_IF)    state_d = IDLE;
    else if (iFRAME_START) state_d = FETCH;
  end

  // Request is computed from next-cycle counts so credit is exact when it becomes visible.
  always_comb begin
    credit_sum = 8'(fifo_count_d) + 8'(outstanding_d);
    if (mem_req_q & iMEM_BUSY & ~flush)
      mem_req_d = 1'b1;
    else
      mem_req_d = (state_d == FETCH) && (discard_d == 7'd0) && (credit_sum < 8'(FIFO_DEPTH));
  end

  always_comb begin
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (flush) begin
      discard_d     = discard_q + outstanding_q + {6'd0, accept} - {6'd0, iMEM_VALID};
      outstanding_d = 7'd0;
    end else begin
      if (accept) outstanding_d = outstanding_d + 7'd1;
      if (iMEM_VALID) begin
        if (discard_q != 7'd0) discard_d     = discard_q - 7'd1;
        else                   outstanding_d = outstanding_d - 7'd1;
      end
    end
  end

  always_comb begin
    fifo_count_d = fifo_count_q;
    if (flush)              fifo_count_d = '0;
    else if (push && !pop)  fifo_count_d = fifo_count_q + {{FIFO_DEPTH_N{1'b0}}, 1'b1};
    else if (pop && !push)  fifo_count_d = fifo_count_q - {{FIFO_DEPTH_N{1'b0}}, 1'b1};
  end

  always_comb begin
    addr_d = addr_q;
    if (flush)       addr_d = 19'd0;
    else if (accept) addr_d = (addr_q == 19'(FRAME_PIXELS - 1)) ? 19'd0 : addr_q + 19'd1;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      mem_req_q     <= 1'b0;
      addr_q        <= 19'd0;
      outstanding_q <= 7'd0;
      discard_q     <= 7'd0;
      fifo_count_q  <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      mem_req_q     <= mem_req_d;
      addr_q        <= addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_count_q  <= fifo_count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + {{(FIFO_DEPTH_N-1){1'b0}}, 1'b1};
        if (pop)  rd_ptr_q <= rd_ptr_q + {{(FIFO_DEPTH_N-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (push) fifo_mem[wr_ptr_q] <= iMEM_DATA;
  end

  assign oMEM_REQ    = mem_req_q;
  assign oMEM_ADDR   = addr_q;
  assign oDISP_VALID = (fifo_count_q != '0);
  assign oDISP_DATA  = oDISP_VALID ? fifo_mem[rd_ptr_q] : 16'd0;

`ifdef VGA_READ_PIXEL_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)                                             underrun_q <= 1'b0;
    else if (flush)                                           underrun_q <= 1'b0;
    else if (iDISP_REQ && !oDISP_VALID && (state_q == FETCH)) underrun_q <= 1'b1;
  end

  assign oDISP_UNDERRUN = underrun_q;
`else
  assign oDISP_UNDERRUN = 1'b0;
`endif
endmodule
